avalon_st_packet_arbiter: RTL and testbench

AVALON_ST_PACKET_ARBITER -- requirements
Module: avalon_st_packet_arbiter

---
 rtl/avalon_st_packet_arbiter.sv | 154 +++++++++++++++
 tb/tb_avalon_st_packet_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_st_packet_arbiter.sv
// Two-input Avalon-ST packet arbiter: round-robin, packet-atomic grant feeding a 2-entry
// output FIFO, with a registered pulse on start-of-packet delimiter violations.
module avalon_st_packet_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in0_valid,
  output logic              in0_ready,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_startofpacket,
  input  logic              in0_endofpacket,
  input  logic              in1_valid,
  output logic              in1_ready,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_startofpacket,
  input  logic              in1_endofpacket,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_startofpacket,
  output logic              out_endofpacket,
  output logic              out_channel,
  output logic              protocol_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
    logic              channel;
  } entry_t;

  state_t     state_q, state_d;
  logic       rrLast_q, rrLast_d;
  logic       firstBeat_q, firstBeat_d;
  logic       protoErr_q, protoErr_d;
  entry_t     fifoMem_q [2];
  logic       wrPtr_q, rdPtr_q;
  logic [1:0] fifoCount_q;

  logic       fifoFull;
  logic       acc0, acc1;
  logic       push, pop;
  entry_t     pushEntry;
  entry_t     headEntry;

  // Only the locked requester sees ready, and only while the FIFO has room.
  assign fifoFull  = (fifoCount_q == 2'd2);
  assign in0_ready = (state_q == LOCK0) && !fifoFull;
  assign in1_ready = (state_q == LOCK1) && !fifoFull;
  assign acc0      = in0_valid && in0_ready;
  assign acc1      = in1_valid && in1_ready;
  assign push      = acc0 || acc1;
  assign pop       = out_valid && out_ready;

  always_comb begin
    pushEntry = {in0_data, in0_startofpacket, in0_endofpacket, 1'b0};
    if (state_q == LOCK1) begin
      pushEntry = {in1_data, in1_startofpacket, in1_endofpacket, 1'b1};
    end
  end

  always_comb begin
    state_d     = state_q;
    rrLast_d    = rrLast_q;
    firstBeat_d = firstBeat_q;
    protoErr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // On contention the requester that did not win last time gets the grant.
        if (in0_valid && (!in1_valid || rrLast_q)) begin
          state_d     = LOCK0;
          rrLast_d    = 1'b0;
          firstBeat_d = 1'b1;
        end else if (in1_valid) begin
          state_d     = LOCK1;
          rrLast_d    = 1'b1;
          firstBeat_d = 1'b1;
        end
      end
      LOCK0: begin
        if (acc0 && in0_endofpacket) begin
          state_d = IDLE;
        end
      end
      LOCK1: begin
        if (acc1 && in1_endofpacket) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (push) begin
      firstBeat_d = 1'b0;
      protoErr_d  = firstBeat_q ? !pushEntry.sop : pushEntry.sop;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rrLast_q    <= 1'b1;
      firstBeat_q <= 1'b0;
      protoErr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rrLast_q    <= rrLast_d;
      firstBeat_q <= firstBeat_d;
      protoErr_q  <= protoErr_d;
    end
  end

  // Storage is cleared on reset so the head entry drives all-zero outputs while empty after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifoMem_q[0] <= '0;
      fifoMem_q[1] <= '0;
      wrPtr_q      <= 1'b0;
      rdPtr_q      <= 1'b0;
      fifoCount_q  <= 2'd0;
    end else begin
      if (push) begin
        fifoMem_q[wrPtr_q] <= pushEntry;
        wrPtr_q            <= !wrPtr_q;
      end
      if (pop) begin
        rdPtr_q <= !rdPtr_q;
      end
      case ({push, pop})
        2'b10:   fifoCount_q <= fifoCount_q + 2'd1;
        2'b01:   fifoCount_q <= fifoCount_q - 2'd1;
        default: fifoCount_q <= fifoCount_q;
      endcase
    end
  end

  assign headEntry         = fifoMem_q[rdPtr_q];
  assign out_valid         = (fifoCount_q != 2'd0);
  assign out_data          = headEntry.data;
  assign out_startofpacket = headEntry.sop;
  assign out_endofpacket   = headEntry.eop;
  assign out_channel       = headEntry.channel;
  assign protocol_err      = protoErr_q;

endmodule

// File: tb/tb_avalon_st_packet_arbiter.sv
// Self-checking bench for avalon_st_packet_arbiter: cycle tables for the directed scenarios,
// hand-written reset and single-beat sequences, and randomized traffic against a packet-level model.
module tb_avalon_st_packet_arbiter;

  localparam int DATA_W = 8;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in0_valid = 1'b0, in0_ready;
  logic [DATA_W-1:0] in0_data = '0;
  logic              in0_startofpacket = 1'b0, in0_endofpacket = 1'b0;
  logic              in1_valid = 1'b0, in1_ready;
  logic [DATA_W-1:0] in1_data = '0;
  logic              in1_startofpacket = 1'b0, in1_endofpacket = 1'b0;
  logic              out_valid, out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              out_startofpacket, out_endofpacket, out_channel, protocol_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  avalon_st_packet_arbiter #(.DATA_W(DATA_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .in0_valid         (in0_valid),
    .in0_ready         (in0_ready),
    .in0_data          (in0_data),
    .in0_startofpacket (in0_startofpacket),
    .in0_endofpacket   (in0_endofpacket),
    .in1_valid         (in1_valid),
    .in1_ready         (in1_ready),
    .in1_data          (in1_data),
    .in1_startofpacket (in1_startofpacket),
    .in1_endofpacket   (in1_endofpacket),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .out_channel       (out_channel),
    .protocol_err      (protocol_err)
  );

  typedef struct {
    logic       rst;
    logic       v0;
    logic [7:0] d0;
    logic       s0, e0;
    logic       v1;
    logic [7:0] d1;
    logic       s1, e1;
    logic       ordy;
    logic       ov;
    logic [7:0] od;
    logic       os, oe, och;
    logic       r0, r1, err;
  } vec_t;

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
  } beat_t;

  vec_t  tab[$];
  beat_t send0[$], send1[$], exp0[$], exp1[$];
  int    gen0, gen1;

  function automatic vec_t mk(input logic rst, input logic v0, input logic [7:0] d0, input logic s0,
                              input logic e0, input logic v1, input logic [7:0] d1, input logic s1,
                              input logic e1, input logic ordy, input logic ov, input logic [7:0] od,
                              input logic os, input logic oe, input logic och, input logic r0,
                              input logic r1, input logic err);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.d0 = d0; v.s0 = s0; v.e0 = e0;
    v.v1 = v1; v.d1 = d1; v.s1 = s1; v.e1 = e1; v.ordy = ordy;
    v.ov = ov; v.od = od; v.os = os; v.oe = oe; v.och = och;
    v.r0 = r0; v.r1 = r1; v.err = err;
    return v;
  endfunction

  function automatic logic [31:0] allOutputs();
    return 32'({out_valid, out_data, out_startofpacket, out_endofpacket, out_channel,
                protocol_err, in0_ready, in1_ready});
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic driveIdle();
    in0_valid = 1'b0; in0_data = '0; in0_startofpacket = 1'b0; in0_endofpacket = 1'b0;
    in1_valid = 1'b0; in1_data = '0; in1_startofpacket = 1'b0; in1_endofpacket = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    driveIdle();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    in0_valid = v.v0; in0_data = v.d0; in0_startofpacket = v.s0; in0_endofpacket = v.e0;
    in1_valid = v.v1; in1_data = v.d1; in1_startofpacket = v.s1; in1_endofpacket = v.e1;
    out_ready = v.ordy;
  endtask

  // Payload fields only matter while out_valid is expected high.
  task automatic checkOutput(input string name, input vec_t v);
    logic [14:0] act, exp;
    act = {out_valid, in0_ready, in1_ready, protocol_err,
           out_valid ? {out_data, out_startofpacket, out_endofpacket, out_channel} : 11'b0};
    exp = {v.ov, v.r0, v.r1, v.err, v.ov ? {v.od, v.os, v.oe, v.och} : 11'b0};
    checkVal(name, 32'(act), 32'(exp));
  endtask

  task automatic genPacket(input logic ch, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = 8'($urandom);
      b.sop  = (i == 0);
      b.eop  = (i == len - 1);
      if (ch) begin
        send1.push_back(b); exp1.push_back(b);
      end else begin
        send0.push_back(b); exp0.push_back(b);
      end
    end
  endtask

  // Sources hold each beat until it is accepted; junk is driven on the data lines while idle.
  task automatic driveRandom(input bit gaps, input int pkts);
    if (send0.size() == 0 && gen0 < pkts) begin
      genPacket(1'b0, gaps ? int'($urandom_range(1, 4)) : 4);
      gen0++;
    end
    if (send1.size() == 0 && gen1 < pkts) begin
      genPacket(1'b1, gaps ? int'($urandom_range(1, 4)) : 1);
      gen1++;
    end
    in0_valid = (send0.size() != 0) && (!gaps || ($urandom_range(0, 3) != 0));
    in1_valid = (send1.size() != 0) && (!gaps || ($urandom_range(0, 3) != 0));
    if (send0.size() != 0) begin
      in0_data = send0[0].data; in0_startofpacket = send0[0].sop; in0_endofpacket = send0[0].eop;
    end else begin
      in0_data = 8'($urandom); in0_startofpacket = 1'($urandom); in0_endofpacket = 1'($urandom);
    end
    if (send1.size() != 0) begin
      in1_data = send1[0].data; in1_startofpacket = send1[0].sop; in1_endofpacket = send1[0].eop;
    end else begin
      in1_data = 8'($urandom); in1_startofpacket = 1'($urandom); in1_endofpacket = 1'($urandom);
    end
    out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Without gaps both sources are always pending, so packet grants must strictly alternate 0,1,0,...
  task automatic randomPhase(input string tag, input bit gaps, input int pkts, input int maxCycles);
    int    cyc = 0;
    int    pktIdx = 0;
    int    errSeen = 0;
    int    bothRdy = 0;
    logic  acc0, acc1;
    logic  inPkt = 1'b0;
    logic  curCh = 1'b0;
    beat_t e;
    send0.delete(); send1.delete(); exp0.delete(); exp1.delete();
    gen0 = 0; gen1 = 0;
    doReset();
    driveRandom(gaps, pkts);
    while (!(gen0 >= pkts && gen1 >= pkts && send0.size() == 0 && send1.size() == 0 &&
             exp0.size() == 0 && exp1.size() == 0) && cyc < maxCycles) begin
      @(negedge clk);
      acc0 = in0_valid && in0_ready;
      acc1 = in1_valid && in1_ready;
      if (in0_ready && in1_ready) bothRdy++;
      if (protocol_err) errSeen++;
      if (out_valid && out_ready) begin
        if ((out_channel && exp1.size() == 0) || (!out_channel && exp0.size() == 0)) begin
          checks++;
          failures++;
          $display("[TB] FAIL %s_unexpectedBeat: got data 0x%0h on channel %0d, expected no beat",
                   tag, out_data, out_channel);
        end else begin
          if (out_channel) e = exp1.pop_front();
          else e = exp0.pop_front();
          checkVal({tag, "_beat"}, 32'({out_data, out_startofpacket, out_endofpacket}),
                   32'({e.data, e.sop, e.eop}));
        end
        if (inPkt) checkVal({tag, "_atomic"}, 32'(out_channel), 32'(curCh));
        if (out_startofpacket) begin
          if (!gaps) checkVal({tag, "_grantOrder"}, 32'(out_channel), 32'(pktIdx % 2));
          pktIdx++;
        end
        inPkt = !out_endofpacket;
        curCh = out_channel;
      end
      @(posedge clk);
      if (acc0) send0.delete(0);
      if (acc1) send1.delete(0);
      #1;
      driveRandom(gaps, pkts);
      cyc++;
    end
    checkVal({tag, "_completed"}, 32'(cyc < maxCycles), 32'd1);
    checkVal({tag, "_protocolErrPulses"}, 32'(errSeen), 32'd0);
    checkVal({tag, "_bothReady"}, 32'(bothRdy), 32'd0);
    checkVal({tag, "_packetCount"}, 32'(pktIdx), 32'(2 * pkts));
  endtask

  initial begin
    logic [7:0] nextD;
    logic [7:0] expD;
    logic       expRdy, expOv;

    // Reset state with busy inputs: everything must stay at zero.
    reset = 1'b1;
    in0_valid = 1'b1; in0_data = 8'hA5; in0_startofpacket = 1'b1;
    in1_valid = 1'b1; in1_data = 8'h5A; in1_startofpacket = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkVal("resetState", allOutputs(), 32'd0);

    // Both requesters start together: in0 packet on cycles 2-4, gap, in1 packet on cycles 6-8.
    //                 rst v0 d0     s0 e0  v1 d1     s1 e1  ordy  ov od     os oe och r0 r1 err
    tab.push_back(mk(H, H, 8'h10, H, L,  H, 8'h20, H, L,  H,    L, 8'h00, L, L, L,  L, L, L));
    tab.push_back(mk(L, H, 8'h10, H, L,  H, 8'h20, H, L,  H,    L, 8'h00, L, L, L,  H, L, L));
    tab.push_back(mk(L, H, 8'h11, L, L,  H, 8'h20, H, L,  H,    H, 8'h10, H, L, L,  H, L, L));
    tab.push_back(mk(L, H, 8'h12, L, H,  H, 8'h20, H, L,  H,    H, 8'h11, L, L, L,  H, L, L));
    tab.push_back(mk(L, L, 8'h00, L, L,  H, 8'h20, H, L,  H,    H, 8'h12, L, H, L,  L, L, L));
    tab.push_back(mk(L, L, 8'h00, L, L,  H, 8'h20, H, L,  H,    L, 8'h00, L, L, L,  L, H, L));
    tab.push_back(mk(L, L, 8'h00, L, L,  H, 8'h21, L, L,  H,    H, 8'h20, H, L, H,  L, H, L));
    tab.push_back(mk(L, L, 8'h00, L, L,  H, 8'h22, L, H,  H,    H, 8'h21, L, L, H,  L, H, L));
    tab.push_back(mk(L, L, 8'h00, L, L,  L, 8'h00, L, L,  H,    H, 8'h22, L, H, H,  L, L, L));
    tab.push_back(mk(L, L, 8'h00, L, L,  L, 8'h00, L, L,  H,    L, 8'h00, L, L, L,  L, L, L));
    // Backpressure: two beats buffered, ready drops, then an in-order drain.
    tab.push_back(mk(H, H, 8'h30, H, L,  L, 8'h00, L, L,  L,    L, 8'h00, L, L, L,  L, L, L));
    tab.push_back(mk(L, H, 8'h30, H, L,  L, 8'h00, L, L,  L,    L, 8'h00, L, L, L,  H, L, L));
    tab.push_back(mk(L, H, 8'h31, L, L,  L, 8'h00, L, L,  L,    H, 8'h30, H, L, L,  H, L, L));
    tab.push_back(mk(L, H, 8'h32, L, L,  L, 8'h00, L, L,  L,    H, 8'h30, H, L, L,  L, L, L));
    tab.push_back(mk(L, H, 8'h32, L, L,  L, 8'h00, L, L,  L,    H, 8'h30, H, L, L,  L, L, L));
    tab.push_back(mk(L, H, 8'h32, L, L,  L, 8'h00, L, L,  H,    H, 8'h30, H, L, L,  L, L, L));
    tab.push_back(mk(L, H, 8'h32, L, L,  L, 8'h00, L, L,  H,    H, 8'h31, L, L, L,  H, L, L));
    tab.push_back(mk(L, H, 8'h33, L, H,  L, 8'h00, L, L,  H,    H, 8'h32, L, L, L,  H, L, L));
    tab.push_back(mk(L, L, 8'h00, L, L,  L, 8'h00, L, L,  H,    H, 8'h33, L, H, L,  L, L, L));
    tab.push_back(mk(L, L, 8'h00, L, L,  L, 8'h00, L, L,  H,    L, 8'h00, L, L, L,  L, L, L));
    // Stray sop on in1 beat 2, then an in0 packet whose first beat lacks sop.
    tab.push_back(mk(H, L, 8'h00, L, L,  H, 8'h40, H, L,  H,    L, 8'h00, L, L, L,  L, L, L));
    tab.push_back(mk(L, L, 8'h00, L, L,  H, 8'h40, H, L,  H,    L, 8'h00, L, L, L,  L, H, L));
    tab.push_back(mk(L, L, 8'h00, L, L,  H, 8'h41, H, L,  H,    H, 8'h40, H, L, H,  L, H, L));
    tab.push_back(mk(L, L, 8'h00, L, L,  H, 8'h42, L, H,  H,    H, 8'h41, H, L, H,  L, H, H));
    tab.push_back(mk(L, L, 8'h00, L, L,  L, 8'h00, L, L,  H,    H, 8'h42, L, H, H,  L, L, L));
    tab.push_back(mk(L, H, 8'h50, L, H,  L, 8'h00, L, L,  H,    L, 8'h00, L, L, L,  L, L, L));
    tab.push_back(mk(L, H, 8'h50, L, H,  L, 8'h00, L, L,  H,    L, 8'h00, L, L, L,  H, L, L));
    tab.push_back(mk(L, L, 8'h00, L, L,  L, 8'h00, L, L,  H,    H, 8'h50, L, H, L,  L, L, H));
    tab.push_back(mk(L, L, 8'h00, L, L,  L, 8'h00, L, L,  H,    L, 8'h00, L, L, L,  L, L, L));

    for (int i = 0; i < tab.size(); i++) begin
      if (tab[i].rst) doReset();
      @(posedge clk);
      #1;
      applyStimulus(tab[i]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d", i), tab[i]);
    end

    // Reset mid-packet with the FIFO full, then a clean single-beat packet.
    doReset();
    @(posedge clk); #1;
    in0_valid = 1'b1; in0_data = 8'h60; in0_startofpacket = 1'b1; in0_endofpacket = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in0_data = 8'h61; in0_startofpacket = 1'b0;
    @(posedge clk); #1;
    in0_data = 8'h62; in0_endofpacket = 1'b1;
    @(negedge clk);
    checkVal("midPktBuffered", 32'({out_valid, in0_ready, out_data}), 32'({1'b1, 1'b0, 8'h60}));
    #2 reset = 1'b1;
    #1 checkVal("resetImmediate", allOutputs(), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    driveIdle();
    out_ready = 1'b1;
    @(posedge clk); #1;
    in0_valid = 1'b1; in0_data = 8'h70; in0_startofpacket = 1'b1; in0_endofpacket = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checkVal("postResetGrant", 32'({in0_ready, protocol_err}), 32'({1'b1, 1'b0}));
    @(posedge clk); #1;
    in0_valid = 1'b0;
    @(negedge clk);
    checkVal("postResetBeat",
             32'({out_valid, out_data, out_startofpacket, out_endofpacket, out_channel, protocol_err}),
             32'({1'b1, 8'h70, 1'b1, 1'b1, 1'b0, 1'b0}));
    @(posedge clk); #1;
    @(negedge clk);
    checkVal("postResetDrained", 32'({out_valid, protocol_err}), 32'd0);

    // Back-to-back single-beat packets on in0: one beat every second cycle.
    doReset();
    nextD = 8'h80;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      in0_valid = 1'b1; in0_data = nextD; in0_startofpacket = 1'b1; in0_endofpacket = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      expRdy = (k % 2 == 1);
      expOv  = (k >= 2) && (k % 2 == 0);
      expD   = 8'(128 + k / 2 - 1);
      checkVal($sformatf("singleBeat_c%0d", k),
               32'({in0_ready, out_valid, out_valid ? {out_data, out_startofpacket, out_endofpacket} : 10'b0}),
               32'({expRdy, expOv, expOv ? {expD, 2'b11} : 10'b0}));
      if (in0_valid && in0_ready) nextD = nextD + 8'd1;
    end

    randomPhase("fairness", 1'b0, 12, 3000);
    randomPhase("randomGaps", 1'b1, 40, 8000);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no completion, expected completion");
    $fatal(1);
  end

endmodule
